// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault-injection campaign sequencer: enables one fault at a time, watches mismatch, streams results.
// Optional macro FAULT_EARLY_EXIT_EN: the first mismatch in OBSERVE cuts the window short.
module fault_campaign_ctrl #(
    parameter int unsigned NSITES = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CW     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          mismatch,
    output logic [NSITES-1:0]             stuck0_en,
    output logic [NSITES-1:0]             stuck1_en,
    output logic                          stim_restart,
    output logic                          busy,
    output logic                          done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(2*NSITES)-1:0]   res_fault,
    output logic                          res_detected,
    output logic [$clog2(WINDOW)-1:0]     res_cycle,
    output logic [CW-1:0]                 det_count,
    output logic [CW-1:0]                 undet_count
);

    localparam int unsigned FW   = $clog2(2*NSITES);
    localparam int unsigned WW   = $clog2(WINDOW);
    localparam int unsigned EW   = 2*NSITES;
    localparam int unsigned SW   = (NSITES > 1) ? $clog2(NSITES) : 1;
    localparam int unsigned CMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned CNTW = $clog2(CMAX);

    localparam logic [FW-1:0]   LAST_F   = FW'(2*NSITES-1);
    localparam logic [CNTW-1:0] OBS_LAST = CNTW'(WINDOW-1);
    localparam logic [CNTW-1:0] SET_LAST = CNTW'((SETTLE > 0) ? SETTLE-1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTART, S_SETTLE, S_OBSERVE, S_RECORD, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fault_q, fault_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            det_flag_q, det_flag_d;
    logic [WW-1:0]   cap_q, cap_d;
    logic [CW-1:0]   det_cnt_q, det_cnt_d;
    logic [CW-1:0]   undet_cnt_q, undet_cnt_d;

    logic [EW-1:0]   en_q, en_d;
    logic            stim_restart_q, stim_restart_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            res_valid_q, res_valid_d;
    logic [FW-1:0]   res_fault_q, res_fault_d;
    logic            res_detected_q, res_detected_d;
    logic [WW-1:0]   res_cycle_q, res_cycle_d;

    logic [SW-1:0]   site_d;
    logic [FW-1:0]   sel_d;

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            fault_q        <= '0;
            cnt_q          <= '0;
            det_flag_q     <= 1'b0;
            cap_q          <= '0;
            det_cnt_q      <= '0;
            undet_cnt_q    <= '0;
            en_q           <= '0;
            stim_restart_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            res_fault_q    <= '0;
            res_detected_q <= 1'b0;
            res_cycle_q    <= '0;
        end else begin
            state_q        <= state_d;
            fault_q        <= fault_d;
            cnt_q          <= cnt_d;
            det_flag_q     <= det_flag_d;
            cap_q          <= cap_d;
            det_cnt_q      <= det_cnt_d;
            undet_cnt_q    <= undet_cnt_d;
            en_q           <= en_d;
            stim_restart_q <= stim_restart_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            res_valid_q    <= res_valid_d;
            res_fault_q    <= res_fault_d;
            res_detected_q <= res_detected_d;
            res_cycle_q    <= res_cycle_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        det_flag_d  = det_flag_q;
        cap_d       = cap_q;
        det_cnt_d   = det_cnt_q;
        undet_cnt_d = undet_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESTART;
                    fault_d     = '0;
                    det_cnt_d   = '0;
                    undet_cnt_d = '0;
                end
            end
            S_RESTART: begin
                cnt_d      = '0;
                det_flag_d = 1'b0;
                cap_d      = '0;
                state_d    = (SETTLE > 0) ? S_SETTLE : S_OBSERVE;
            end
            S_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = S_OBSERVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OBSERVE: begin
                cnt_d = cnt_q + 1'b1;
                if (mismatch && !det_flag_q) begin
                    det_flag_d = 1'b1;
                    cap_d      = WW'(cnt_q);
                end
`ifdef FAULT_EARLY_EXIT_EN
                if ((cnt_q == OBS_LAST) || mismatch) state_d = S_RECORD;
`else
                if (cnt_q == OBS_LAST) state_d = S_RECORD;
`endif
            end
            S_RECORD: begin
                if (res_ready) begin
                    if (det_flag_q) begin
                        if (det_cnt_q != {CW{1'b1}}) det_cnt_d = det_cnt_q + 1'b1;
                    end else begin
                        if (undet_cnt_q != {CW{1'b1}}) undet_cnt_d = undet_cnt_q + 1'b1;
                    end
                    if (fault_q == LAST_F) begin
                        state_d = S_DONE;
                    end else begin
                        fault_d = fault_q + 1'b1;
                        state_d = S_RESTART;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over start and the result handshake; counters keep their values
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d     = S_IDLE;
            det_cnt_d   = det_cnt_q;
            undet_cnt_d = undet_cnt_q;
        end
    end

    // Outputs decoded from the next state so they land in registers aligned with it
    always_comb begin
        en_d           = '0;
        site_d         = SW'(fault_d >> 1);
        sel_d          = fault_d[0] ? (FW'(NSITES) + FW'(site_d)) : FW'(site_d);
        stim_restart_d = (state_d == S_RESTART);
        busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d         = (state_d == S_DONE);
        res_valid_d    = (state_d == S_RECORD);
        res_fault_d    = fault_d;
        res_detected_d = det_flag_d;
        res_cycle_d    = cap_d;
        if ((state_d == S_RESTART) || (state_d == S_SETTLE) || (state_d == S_OBSERVE)) begin
            en_d = EW'(1) << sel_d;
        end
    end

    assign stuck0_en    = en_q[NSITES-1:0];
    assign stuck1_en    = en_q[EW-1:NSITES];
    assign stim_restart = stim_restart_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign res_valid    = res_valid_q;
    assign res_fault    = res_fault_q;
    assign res_detected = res_detected_q;
    assign res_cycle    = res_cycle_q;
    assign det_count    = det_cnt_q;
    assign undet_count  = undet_cnt_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl (NSITES=4, SETTLE=2, WINDOW=8) with a result scoreboard.
module tb_fault_campaign_ctrl;

    localparam int NS  = 4;
    localparam int ST  = 2;
    localparam int WIN = 8;
    localparam int NF  = 2*NS;

    typedef struct packed {
        logic [2:0] f;
        logic       det;
        logic [2:0] cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          mismatch;
    logic [NS-1:0] stuck0_en;
    logic [NS-1:0] stuck1_en;
    logic          stim_restart;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready;
    logic [2:0]    res_fault;
    logic          res_detected;
    logic [2:0]    res_cycle;
    logic [15:0]   det_count;
    logic [15:0]   undet_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_det = 0;
    int   m_undet = 0;
    exp_t sb[$];

    fault_campaign_ctrl #(.NSITES(NS), .SETTLE(ST), .WINDOW(WIN), .CW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mismatch(mismatch),
        .stuck0_en(stuck0_en), .stuck1_en(stuck1_en), .stim_restart(stim_restart),
        .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
        .res_fault(res_fault), .res_detected(res_detected), .res_cycle(res_cycle),
        .det_count(det_count), .undet_count(undet_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_fault(input int f, input int det_cyc, input bit settle_mm,
                            input int rdy_delay, input bit poke);
        exp_t       e;
        logic [7:0] exp_en;
        exp_en = 8'(1) << ((f % 2) * NS + f / 2);
        e.f    = 3'(f);
        e.det  = (det_cyc >= 0);
        e.cyc  = (det_cyc >= 0) ? 3'(det_cyc) : 3'd0;
        sb.push_back(e);
        for (int i = 0; i < 20 && stim_restart !== 1'b1; i++) @(negedge clk);
        chk("restart_pulse", 32'(stim_restart), 1);
        chk("en_restart", 32'({stuck1_en, stuck0_en}), 32'(exp_en));
        chk("busy_restart", 32'(busy), 1);
        mismatch = 1'b0;
        for (int s = 0; s < ST; s++) begin
            @(negedge clk);
            mismatch = settle_mm;
            start    = poke && (s == 0);
            chk("en_settle", 32'({stuck1_en, stuck0_en}), 32'(exp_en));
            chk("restart_low_settle", 32'(stim_restart), 0);
        end
        for (int o = 0; o < WIN; o++) begin
            @(negedge clk);
            start    = 1'b0;
            mismatch = (o == det_cyc);
            chk("en_observe", 32'({stuck1_en, stuck0_en}), 32'(exp_en));
            chk("valid_low_observe", 32'(res_valid), 0);
`ifdef FAULT_EARLY_EXIT_EN
            if (o == det_cyc) break;
`endif
        end
        @(negedge clk);
        mismatch = 1'b0;
        chk("valid_record", 32'(res_valid), 1);
        chk("en_off_record", 32'({stuck1_en, stuck0_en}), 0);
        if (rdy_delay > 0) begin
            res_ready = 1'b0;
            for (int d = 0; d < rdy_delay; d++) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_fault", 32'(res_fault), 32'(e.f));
                chk("hold_det", 32'(res_detected), 32'(e.det));
                chk("hold_cycle", 32'(res_cycle), 32'(e.cyc));
                chk("hold_en_off", 32'({stuck1_en, stuck0_en}), 0);
                chk("hold_det_count", 32'(det_count), 32'(m_det));
                chk("hold_undet_count", 32'(undet_count), 32'(m_undet));
                @(negedge clk);
            end
            res_ready = 1'b1;
        end
        e = sb.pop_front();
        chk("res_fault", 32'(res_fault), 32'(e.f));
        chk("res_detected", 32'(res_detected), 32'(e.det));
        chk("res_cycle", 32'(res_cycle), 32'(e.cyc));
        @(negedge clk);
        if (e.det) m_det++;
        else       m_undet++;
        chk("det_count", 32'(det_count), 32'(m_det));
        chk("undet_count", 32'(undet_count), 32'(m_undet));
        chk("valid_fall", 32'(res_valid), 0);
    endtask

    task automatic run_campaign(input int det_f, input int det_c, input bit settle_mm,
                                input int delay_f, input int poke_f);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_det   = 0;
        m_undet = 0;
        for (int f = 0; f < NF; f++)
            do_fault(f, (f == det_f) ? det_c : -1, settle_mm, (f == delay_f) ? 5 : 0, f == poke_f);
        chk("done_end", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("en_end", 32'({stuck1_en, stuck0_en}), 0);
        chk("det_end", 32'(det_count), 32'(m_det));
        chk("undet_end", 32'(undet_count), 32'(m_undet));
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mismatch  = 1'b0;
        res_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_en", 32'({stuck1_en, stuck0_en}), 0);
        chk("rst_counts", 32'({det_count, undet_count}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of OBSERVE
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_restart", 32'(stim_restart), 1);
        repeat (ST + 2) @(negedge clk);
        chk("pre_rst_en", 32'({stuck1_en, stuck0_en}), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 32'({stuck1_en, stuck0_en}), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_restart", 32'(stim_restart), 0);
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_fault", 32'(res_fault), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst_busy", 32'(busy), 0);
        chk("idle_after_rst_done", 32'(done), 0);

        // All undetected, with a stray start while busy on fault 1
        run_campaign(-1, 0, 1'b0, -1, 1);
        chk("campaign_a_undet", 32'(undet_count), 8);

        // Single mismatch in observe cycle 3 of fault 5
        run_campaign(5, 3, 1'b0, -1, -1);
        chk("campaign_b_det", 32'(det_count), 1);
        chk("campaign_b_undet", 32'(undet_count), 7);

        // Mismatch only during SETTLE, and backpressure on fault 2
        run_campaign(-1, 0, 1'b1, 2, -1);
        chk("campaign_c_undet", 32'(undet_count), 8);

        // Abort during OBSERVE of fault 3
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_det   = 0;
        m_undet = 0;
        for (int f = 0; f < 3; f++) do_fault(f, -1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20 && stim_restart !== 1'b1; i++) @(negedge clk);
        chk("abort_restart", 32'(stim_restart), 1);
        repeat (ST + 2) @(negedge clk);
        chk("abort_pre_en", 32'(stuck1_en), 32'(4'b0010));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_en", 32'({stuck1_en, stuck0_en}), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_restart_low", 32'(stim_restart), 0);
        chk("abort_det", 32'(det_count), 0);
        chk("abort_undet", 32'(undet_count), 3);
        sb.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
